// File: rtl/set_job_scheduler_pkg.sv
// Shared types and widths for the SET job scheduler: FSM states, field widths
// and the circular pointer increment used by the round-robin grant.
package set_job_scheduler_pkg;

  localparam int CENTRAL_W = 16;
  localparam int RADIUS_W  = 8;
  localparam int CAND_W    = 4;
  localparam int JOBS_W    = 16;
  localparam int TMO_W     = 5;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE,
    RESP
  } state_e;

  // Pointer wraps at n, not at the next power of two.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/set_job_scheduler_if.sv
// Request, engine and response signals of the SET job scheduler.
// slave = the scheduler itself, master = the surrounding host/engine side.
interface set_job_scheduler_if import set_job_scheduler_pkg::*; #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);

  logic [NREQ-1:0]           req_valid;
  logic [CENTRAL_W*NREQ-1:0] req_central;
  logic [RADIUS_W*NREQ-1:0]  req_radius;
  logic [NREQ-1:0]           req_ready;

  logic                      eng_en;
  logic [CENTRAL_W-1:0]      eng_central;
  logic [RADIUS_W-1:0]       eng_radius;
  logic                      eng_busy;
  logic                      eng_valid;
  logic [CAND_W-1:0]         eng_candidate;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [IDW-1:0]            rsp_id;
  logic [CAND_W-1:0]         rsp_candidate;
  logic                      rsp_err;
  logic [JOBS_W-1:0]         jobs_done;

  modport slave (
    input  req_valid, req_central, req_radius,
    input  eng_busy, eng_valid, eng_candidate,
    input  rsp_ready,
    output req_ready,
    output eng_en, eng_central, eng_radius,
    output rsp_valid, rsp_id, rsp_candidate, rsp_err, jobs_done
  );

  modport master (
    output req_valid, req_central, req_radius,
    output eng_busy, eng_valid, eng_candidate,
    output rsp_ready,
    input  req_ready,
    input  eng_en, eng_central, eng_radius,
    input  rsp_valid, rsp_id, rsp_candidate, rsp_err, jobs_done
  );

endinterface

// File: rtl/set_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requesting port at or after the
// pointer, searching circularly over NREQ ports.
module set_job_scheduler_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx
);

  logic [IDW:0] w_k;
  logic         w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_k = {1'b0, i_ptr} + (IDW+1)'(i);
      if (w_k >= (IDW+1)'(NREQ)) w_k = w_k - (IDW+1)'(NREQ);
      if (!w_found && i_req[w_k[IDW-1:0]]) begin
        w_found                  = 1'b1;
        o_grant[w_k[IDW-1:0]]    = 1'b1;
        o_idx                    = w_k[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/set_job_scheduler.sv
// Shares one SET circle-intersection engine among NREQ requesters: one job in
// flight, round-robin grant, timeout-guarded wait, tagged response.
module set_job_scheduler import set_job_scheduler_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 31
) (
  input  logic               clk,
  input  logic               rst,
  set_job_scheduler_if.slave io_bus
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [IDW-1:0]       r_rr;
  logic [IDW-1:0]       r_id;
  logic [CENTRAL_W-1:0] r_central;
  logic [RADIUS_W-1:0]  r_radius;
  logic [TMO_W-1:0]     r_tmo;
  logic [CAND_W-1:0]    r_rsp_cand;
  logic                 r_rsp_err;
  logic [JOBS_W-1:0]    r_jobs_done;

  logic [NREQ-1:0]      w_grant;
  logic [IDW-1:0]       w_grant_idx;
  logic [NREQ-1:0]      w_req_ready;
  logic                 w_eng_en;
  logic                 w_any;
  logic                 w_tmo_hit;
  logic [CENTRAL_W-1:0] w_sel_central;
  logic [RADIUS_W-1:0]  w_sel_radius;

  set_job_scheduler_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req   (io_bus.req_valid),
    .i_ptr   (r_rr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx)
  );

  assign w_any     = |io_bus.req_valid;
  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT - 1));

  always_comb begin
    w_sel_central = '0;
    w_sel_radius  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_sel_central = io_bus.req_central[k*CENTRAL_W +: CENTRAL_W];
        w_sel_radius  = io_bus.req_radius[k*RADIUS_W +: RADIUS_W];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_eng_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_req_ready = w_grant;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        w_eng_en    = 1'b1;
        w_state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (!io_bus.eng_valid)  w_state_nxt = WAIT_DONE;
        else if (w_tmo_hit)     w_state_nxt = RESP;
      end
      WAIT_DONE: begin
        if (io_bus.eng_valid || w_tmo_hit) w_state_nxt = RESP;
      end
      RESP: begin
        if (io_bus.rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr        <= '0;
      r_id        <= '0;
      r_central   <= '0;
      r_radius    <= '0;
      r_tmo       <= '0;
      r_rsp_cand  <= '0;
      r_rsp_err   <= 1'b0;
      r_jobs_done <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_central <= w_sel_central;
            r_radius  <= w_sel_radius;
            r_id      <= w_grant_idx;
            r_rr      <= IDW'(wrap_inc(int'(w_grant_idx), NREQ));
          end
        end
        LAUNCH: r_tmo <= '0;
        WAIT_START: begin
          // Counter restarts when the engine leaves Prep, so WAIT_DONE gets a fresh budget.
          r_tmo <= io_bus.eng_valid ? r_tmo + TMO_W'(1) : '0;
          if (io_bus.eng_valid && w_tmo_hit) begin
            r_rsp_cand <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        WAIT_DONE: begin
          r_tmo <= r_tmo + TMO_W'(1);
          if (io_bus.eng_valid) begin
            r_rsp_cand <= io_bus.eng_candidate;
            r_rsp_err  <= 1'b0;
          end else if (w_tmo_hit) begin
            r_rsp_cand <= '0;
            r_rsp_err  <= 1'b1;
          end
        end
        RESP: begin
          if (io_bus.rsp_ready) r_jobs_done <= r_jobs_done + JOBS_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign io_bus.req_ready     = w_req_ready;
  assign io_bus.eng_en        = w_eng_en;
  assign io_bus.eng_central   = r_central;
  assign io_bus.eng_radius    = r_radius;
  assign io_bus.rsp_valid     = (r_state == RESP);
  assign io_bus.rsp_id        = r_id;
  assign io_bus.rsp_candidate = r_rsp_cand;
  assign io_bus.rsp_err       = r_rsp_err;
  assign io_bus.jobs_done     = r_jobs_done;

  a_busy_quiet: assert property (@(posedge clk) disable iff (rst)
    !(io_bus.eng_busy && (r_state == IDLE || r_state == RESP)));

endmodule

// File: tb/tb_set_job_scheduler.sv
// Bench for set_job_scheduler: 4-port instance driven by directed and random jobs
// against a transaction-level model, plus a 3-port instance for pointer wrap.
module tb_set_job_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  set_job_scheduler_if #(.NREQ(4), .IDW(2)) if4 ();
  set_job_scheduler_if #(.NREQ(3), .IDW(2)) if3 ();

  set_job_scheduler #(.NREQ(4), .IDW(2), .TIMEOUT(31)) u_dut4 (
    .clk(clk), .rst(rst), .io_bus(if4)
  );
  set_job_scheduler #(.NREQ(3), .IDW(2), .TIMEOUT(31)) u_dut3 (
    .clk(clk), .rst(rst), .io_bus(if3)
  );

  int n_vec = 0;
  int n_err = 0;
  int rr_model = 0;
  int jobs_model = 0;

  // Engine model: result appears eng_lat cycles after Prep is left; hang never finishes.
  int         eng_lat = 1;
  logic [3:0] eng_cand_set = 4'd0;
  bit         eng_hang = 1'b0;
  int         e_cnt;

  always @(posedge clk) begin
    if (rst) begin
      if4.eng_valid     <= 1'b1;
      if4.eng_busy      <= 1'b0;
      if4.eng_candidate <= 4'd0;
      e_cnt             <= 0;
    end else if (if4.eng_en) begin
      if4.eng_valid <= 1'b0;
      if4.eng_busy  <= !eng_hang;
      e_cnt         <= eng_lat;
    end else if (!if4.eng_valid && !eng_hang) begin
      if (e_cnt <= 1) begin
        if4.eng_valid     <= 1'b1;
        if4.eng_busy      <= 1'b0;
        if4.eng_candidate <= eng_cand_set;
      end else begin
        e_cnt <= e_cnt - 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst) if3.eng_valid <= 1'b1;
    else     if3.eng_valid <= !if3.eng_en;
  end
  assign if3.eng_busy      = 1'b0;
  assign if3.eng_candidate = 4'd5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic [7:0] v, input int ptr, input int n);
    for (int i = 0; i < n; i++) if (v[(ptr + i) % n]) return (ptr + i) % n;
    return -1;
  endfunction

  task automatic rand_data();
    if4.req_central = {$urandom, $urandom};
    if4.req_radius  = $urandom;
  endtask

  // Called at a negedge with the scheduler idle; returns at the negedge after acceptance.
  task automatic run_job(input logic [3:0] vld, input logic [3:0] cand, input int lat,
                         input bit hang, input int hold, output int g);
    int d, extra_en, exp_d;
    logic [15:0] exp_c;
    logic [7:0]  exp_r;
    logic [3:0]  exp_cand;
    eng_cand_set = cand;
    eng_lat      = lat;
    eng_hang     = hang;
    g        = model_grant({4'd0, vld}, rr_model, 4);
    exp_c    = if4.req_central[g*16 +: 16];
    exp_r    = if4.req_radius[g*8 +: 8];
    exp_cand = hang ? 4'd0 : cand;
    exp_d    = hang ? 33 : lat + 2;
    if4.req_valid = vld;
    #1;
    chk("req_ready", if4.req_ready, 32'd1 << g);
    @(posedge clk);
    rr_model = (g + 1) % 4;
    @(negedge clk);
    if4.req_valid = '0;
    chk("eng_en_launch", if4.eng_en, 1);
    chk("eng_central", if4.eng_central, exp_c);
    chk("eng_radius", if4.eng_radius, exp_r);
    d = 0;
    extra_en = 0;
    while (!if4.rsp_valid && d < 100) begin
      @(negedge clk);
      d++;
      if (if4.eng_en) extra_en++;
    end
    chk("rsp_latency", d, exp_d);
    chk("eng_en_extra", extra_en, 0);
    chk("rsp_id", if4.rsp_id, g);
    chk("rsp_candidate", if4.rsp_candidate, exp_cand);
    chk("rsp_err", if4.rsp_err, hang);
    for (int i = 0; i < hold; i++) begin
      if4.req_valid = 4'hf;
      @(negedge clk);
      chk("bp_valid", if4.rsp_valid, 1);
      chk("bp_id", if4.rsp_id, g);
      chk("bp_cand", if4.rsp_candidate, exp_cand);
      chk("bp_req_ready", if4.req_ready, 0);
      chk("bp_eng_en", if4.eng_en, 0);
    end
    if4.req_valid = '0;
    if4.rsp_ready = 1'b1;
    @(posedge clk);
    jobs_model++;
    @(negedge clk);
    if4.rsp_ready = 1'b0;
    chk("rsp_drop", if4.rsp_valid, 0);
    chk("jobs_done", if4.jobs_done, jobs_model);
    eng_hang = 1'b0;
  endtask

  int g, d, cnt, rr3;

  initial begin
    if4.req_valid = '0; if4.req_central = '0; if4.req_radius = '0; if4.rsp_ready = 1'b0;
    if3.req_valid = '0; if3.req_central = '0; if3.req_radius = '0; if3.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", if4.req_ready, 0);
    chk("rst_eng_en", if4.eng_en, 0);
    chk("rst_eng_central", if4.eng_central, 0);
    chk("rst_eng_radius", if4.eng_radius, 0);
    chk("rst_rsp_valid", if4.rsp_valid, 0);
    chk("rst_rsp_id", if4.rsp_id, 0);
    chk("rst_rsp_cand", if4.rsp_candidate, 0);
    chk("rst_rsp_err", if4.rsp_err, 0);
    chk("rst_jobs_done", if4.jobs_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // single job on port 2
    rand_data();
    if4.req_central[47:32] = 16'h3355;
    if4.req_radius[23:16]  = 8'h44;
    run_job(4'b0100, 4'd9, 3, 1'b0, 0, g);
    chk("t1_grant", g, 2);
    chk("t1_jobs", if4.jobs_done, 1);

    // backpressure
    rand_data();
    run_job(4'($urandom_range(1, 15)), 4'($urandom), 4, 1'b0, 10, g);

    // timeout, then done on the last allowed cycle
    rand_data();
    run_job(4'b1000, 4'd6, 1, 1'b1, 1, g);
    repeat (20) @(negedge clk);
    rand_data();
    run_job(4'b0001, 4'd11, 31, 1'b0, 0, g);

    // reset mid-job in WAIT_DONE
    eng_lat = 20; eng_hang = 1'b0; eng_cand_set = 4'd7;
    if4.req_valid = 4'b0010;
    #1;
    chk("t5_grant", if4.req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    if4.req_valid = '0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("t5_req_ready", if4.req_ready, 0);
    chk("t5_eng_en", if4.eng_en, 0);
    chk("t5_eng_central", if4.eng_central, 0);
    chk("t5_eng_radius", if4.eng_radius, 0);
    chk("t5_rsp_valid", if4.rsp_valid, 0);
    chk("t5_rsp_cand", if4.rsp_candidate, 0);
    chk("t5_jobs_done", if4.jobs_done, 0);
    rr_model = 0;
    jobs_model = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if4.rsp_valid) cnt++;
    end
    chk("t5_no_rsp", cnt, 0);

    // fairness with every port requesting
    for (int j = 0; j < 6; j++) begin
      rand_data();
      run_job(4'hf, 4'($urandom), 2, 1'b0, 0, g);
      chk("t2_order", g, j % 4);
    end

    // random jobs
    for (int j = 0; j < 12; j++) begin
      rand_data();
      run_job(4'($urandom_range(1, 15)), 4'($urandom), $urandom_range(1, 12), 1'b0,
              $urandom_range(0, 3), g);
    end

    // three-port instance: pointer wraps at 3
    rr3 = 0;
    for (int j = 0; j < 4; j++) begin
      if3.req_valid = 3'b110;
      g = model_grant(8'b0000_0110, rr3, 3);
      #1;
      chk("n3_grant", if3.req_ready, 32'd1 << g);
      @(posedge clk);
      rr3 = (g + 1) % 3;
      @(negedge clk);
      if3.req_valid = '0;
      d = 0;
      while (!if3.rsp_valid && d < 50) begin
        @(negedge clk);
        d++;
      end
      chk("n3_rsp_seen", (d < 50), 1);
      chk("n3_id", if3.rsp_id, g);
      chk("n3_cand", if3.rsp_candidate, 5);
      if3.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if3.rsp_ready = 1'b0;
    end
    chk("n3_jobs", if3.jobs_done, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
